// File: rtl/serial_pkg.sv
// Shared definitions for the serial receiver/transmitter pair: FSM state
// encoding and bit-period arithmetic, so both ends agree on the baud timing.
package serial_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // A degenerate ratio still yields one clock per bit so counters stay sane.
  function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                               input int unsigned baud);
    if ((baud == 32'd0) || (clk_hz < baud)) begin
      return 32'd1;
    end else begin
      return clk_hz / baud;
    end
  endfunction

  function automatic int unsigned cnt_width(input int unsigned n);
    if (n <= 32'd2) begin
      return 32'd1;
    end else begin
      return $clog2(n);
    end
  endfunction

endpackage

// File: rtl/serial_rx_if.sv
// Received-byte bundle: data with its strobes and the busy indicator.
interface serial_rx_if;

  logic [7:0] data;
  logic       valid;
  logic       busy;
  logic       frame_err;

  modport master (output data, output valid, output busy, output frame_err);
  modport slave  (input data, input valid, input busy, input frame_err);

endinterface

// File: rtl/serial_sync.sv
// Two-flop synchronizer for a single asynchronous input with a selectable
// reset value (idle level of the line).
module serial_sync #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability filter: two back-to-back flops, both reset to the idle level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RESET_VAL;
      sync_r <= RESET_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/serial_rx.sv
// 8N1 UART receiver: mid-bit sampling from a half-bit-delayed start check,
// registered byte output with one-cycle valid / frame_err strobes.
module serial_rx
  import serial_pkg::*;
#(
  parameter int unsigned CLK_HZ = 25_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rx,
  serial_rx_if.master   rx_bus
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);
  localparam int unsigned HALF_BIT     = (CLKS_PER_BIT < 32'd2) ? 32'd1 : (CLKS_PER_BIT / 32'd2);
  localparam int unsigned CNT_W        = cnt_width(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 32'd1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 32'd1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

  logic             rx_s;

  state_t           state_r,   state_nx_s;
  logic [CNT_W-1:0] cnt_r,     cnt_nx_s;
  logic [2:0]       bit_idx_r, bit_idx_nx_s;
  logic [7:0]       shift_r,   shift_nx_s;
  logic [7:0]       data_r,    data_nx_s;
  logic             valid_r,   valid_nx_s;
  logic             busy_r,    busy_nx_s;
  logic             ferr_r,    ferr_nx_s;
  logic             half_done_s;
  logic             bit_done_s;

  serial_sync #(
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rx_s)
  );

  assign half_done_s = (cnt_r == HALF_LAST);
  assign bit_done_s  = (cnt_r == BIT_LAST);

  // State and datapath registers; every output is taken straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      data_r    <= 8'h00;
      valid_r   <= 1'b0;
      busy_r    <= 1'b0;
      ferr_r    <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      cnt_r     <= cnt_nx_s;
      bit_idx_r <= bit_idx_nx_s;
      shift_r   <= shift_nx_s;
      data_r    <= data_nx_s;
      valid_r   <= valid_nx_s;
      busy_r    <= busy_nx_s;
      ferr_r    <= ferr_nx_s;
    end
  end

  // Next-state logic: the counter stops at its terminal value and reloads, so it never wraps.
  always_comb begin
    state_nx_s   = state_r;
    cnt_nx_s     = cnt_r;
    bit_idx_nx_s = bit_idx_r;
    shift_nx_s   = shift_r;
    data_nx_s    = data_r;
    valid_nx_s   = 1'b0;
    ferr_nx_s    = 1'b0;
    busy_nx_s    = busy_r;

    case (state_r)
      ST_IDLE: begin
        cnt_nx_s     = CNT_ZERO;
        bit_idx_nx_s = 3'd0;
        if (!rx_s) begin
          state_nx_s = ST_START;
          busy_nx_s  = 1'b1;
        end else begin
          busy_nx_s  = 1'b0;
        end
      end

      ST_START: begin
        if (half_done_s) begin
          cnt_nx_s = CNT_ZERO;
          if (!rx_s) begin
            state_nx_s = ST_DATA;
          end else begin
            // Line went back high before mid-start-bit: a glitch, not a frame.
            state_nx_s = ST_IDLE;
            busy_nx_s  = 1'b0;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end

      ST_DATA: begin
        if (bit_done_s) begin
          cnt_nx_s   = CNT_ZERO;
          shift_nx_s = {rx_s, shift_r[7:1]};
          if (bit_idx_r == LAST_BIT) begin
            state_nx_s   = ST_STOP;
            bit_idx_nx_s = 3'd0;
          end else begin
            bit_idx_nx_s = bit_idx_r + 3'd1;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end

      ST_STOP: begin
        if (bit_done_s) begin
          cnt_nx_s   = CNT_ZERO;
          state_nx_s = ST_IDLE;
          busy_nx_s  = 1'b0;
          if (rx_s) begin
            data_nx_s  = shift_r;
            valid_nx_s = 1'b1;
          end else begin
            ferr_nx_s  = 1'b1;
          end
        end else begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end
      end

      default: begin
        state_nx_s   = ST_IDLE;
        cnt_nx_s     = CNT_ZERO;
        bit_idx_nx_s = 3'd0;
        busy_nx_s    = 1'b0;
      end
    endcase
  end

  assign rx_bus.data      = data_r;
  assign rx_bus.valid     = valid_r;
  assign rx_bus.busy      = busy_r;
  assign rx_bus.frame_err = ferr_r;

endmodule

// File: tb/tb_serial_rx.sv
// Directed + randomized bench for serial_rx: the bench plays the transmitter,
// a frame-level model predicts strobes and bytes, immediate assertions compare.
module tb_serial_rx;

  localparam int unsigned CLK_HZ   = 25_000_000;
  localparam int unsigned BAUD     = 115200;
  localparam int          CPB      = CLK_HZ / BAUD;
  localparam int          HALF     = CPB / 2;
  localparam int          LAT      = 2 + HALF + 9 * CPB;
  localparam int          STOP_LOW = 150;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic rx    = 1'b1;

  serial_rx_if bus ();

  serial_rx #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rx     (rx),
    .rx_bus (bus)
  );

  always #20 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  int valid_cnt   = 0;
  int ferr_cnt    = 0;
  int both_cnt    = 0;
  int busy_cycles = 0;
  logic [7:0] got_q [$];

  int exp_valid = 0;
  int exp_ferr  = 0;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] exp_q [$];

  // Observe strobes away from the rising edge.
  always @(negedge clk) begin
    if (bus.valid) begin
      valid_cnt = valid_cnt + 1;
      got_q.push_back(bus.data);
    end
    if (bus.frame_err) ferr_cnt = ferr_cnt + 1;
    if (bus.valid && bus.frame_err) both_cnt = both_cnt + 1;
    if (bus.busy) busy_cycles = busy_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_checks++;
    assert ((obs >= lo) && (obs <= hi)) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // One 8N1 frame, LSB first, bit period p; a low stop bit lasts STOP_LOW clocks.
  task automatic send_frame(input logic [7:0] b, input int p, input logic stop_val, input int gap);
    rx = 1'b0;
    repeat (p) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (p) @(negedge clk);
    end
    rx = stop_val;
    repeat (stop_val ? p : STOP_LOW) @(negedge clk);
    rx = 1'b1;
    repeat (gap) @(negedge clk);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop_val);
    if (stop_val) begin
      exp_valid++;
      exp_data = b;
      exp_q.push_back(b);
    end else begin
      exp_ferr++;
    end
  endtask

  task automatic verify(input string step);
    check($sformatf("%s.valid_count", step), valid_cnt, exp_valid);
    check($sformatf("%s.ferr_count", step), ferr_cnt, exp_ferr);
    check($sformatf("%s.data", step), {24'h0, bus.data}, {24'h0, exp_data});
    while ((exp_q.size() > 0) && (got_q.size() > 0)) begin
      check($sformatf("%s.byte", step), {24'h0, got_q.pop_front()}, {24'h0, exp_q.pop_front()});
    end
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int n;
    logic [7:0] b;
    int p;
    logic stop_v;
    logic [7:0] abort_byte;

    // Reset state
    repeat (5) @(negedge clk);
    check("reset.data", {24'h0, bus.data}, 32'h0);
    check("reset.valid", {31'h0, bus.valid}, 32'h0);
    check("reset.busy", {31'h0, bus.busy}, 32'h0);
    check("reset.frame_err", {31'h0, bus.frame_err}, 32'h0);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Loopback byte with latency measurement
    n = 0;
    fork
      send_frame(8'hDE, CPB, 1'b1, 300);
      begin
        while (n < LAT + 100) begin
          @(posedge clk);
          n++;
          #1;
          if (bus.valid) break;
        end
      end
    join
    check_range("latency", n, LAT - 1, LAT + 1);
    model_frame(8'hDE, 1'b1);
    verify("loopback");

    // Back-to-back frames, no idle gap
    send_frame(8'h55, CPB, 1'b1, 0);
    send_frame(8'hAA, CPB, 1'b1, 300);
    model_frame(8'h55, 1'b1);
    model_frame(8'hAA, 1'b1);
    verify("back2back");

    // Short low glitch: busy for about half a bit, no strobes
    busy_cycles = 0;
    rx = 1'b0;
    repeat (50) @(negedge clk);
    rx = 1'b1;
    repeat (300) @(negedge clk);
    check_range("glitch.busy_cycles", busy_cycles, HALF - 1, HALF + 1);
    verify("glitch");

    // Framing error keeps the previous byte
    send_frame(8'hFF, CPB, 1'b0, 300);
    model_frame(8'hFF, 1'b0);
    verify("framing");

    // Reset during bit 4 aborts the frame
    abort_byte = 8'hDE;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = abort_byte[i];
      repeat (CPB) @(negedge clk);
    end
    rx = abort_byte[4];
    repeat (100) @(negedge clk);
    rst_n = 1'b0;
    rx = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset.busy", {31'h0, bus.busy}, 32'h0);
    check("midreset.data", {24'h0, bus.data}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_data = 8'h00;
    repeat (300) @(negedge clk);
    verify("midreset.abort");
    send_frame(8'h3C, CPB, 1'b1, 300);
    model_frame(8'h3C, 1'b1);
    verify("midreset.resume");

    // Baud tolerance at both extremes
    send_frame(8'hDE, CPB - 4, 1'b1, 300);
    model_frame(8'hDE, 1'b1);
    verify("baud_fast");
    send_frame(8'hDE, CPB + 4, 1'b1, 300);
    model_frame(8'hDE, 1'b1);
    verify("baud_slow");

    // Random bytes, bit periods and stop-bit faults
    for (int k = 0; k < 12; k++) begin
      b      = 8'($urandom_range(0, 255));
      p      = CPB - 4 + int'($urandom_range(0, 8));
      stop_v = ($urandom_range(0, 3) != 0);
      send_frame(b, p, stop_v, stop_v ? int'($urandom_range(0, 40)) : 300);
      model_frame(b, stop_v);
      if (!stop_v || (k == 11)) begin
        repeat (300) @(negedge clk);
      end else begin
        repeat (0) @(negedge clk);
      end
      repeat (260) @(negedge clk);
      verify($sformatf("random%0d", k));
    end

    check("never_both_strobes", both_cnt, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_rx.md
SERIAL_RX -- requirements
Module: serial_rx

Interface
REQ-001 The block SHALL take parameter CLK_HZ, default 25_000_000, system clock frequency in Hz.
REQ-002 The block SHALL take parameter BAUD, default 115200, line bit rate.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all logic rises on its posedge.
REQ-004 The block SHALL have port rst_n, input, 1 bit; reset is asynchronous and active-low.
REQ-005 The block SHALL have port rx, input, 1 bit, asynchronous serial line, idle high; it is the SerialTX tx output or an external pin.
REQ-006 The block SHALL have port data, output, 8 bits, last correctly framed byte, held until the next good frame.
REQ-007 The block SHALL have port valid, output, 1 bit, one-cycle strobe: data was just updated.
REQ-008 The block SHALL have port busy, output, 1 bit, high from start-edge detect until the stop-bit sample.
REQ-009 The block SHALL have port frame_err, output, 1 bit, one-cycle strobe: stop bit sampled low.

Function
REQ-010 CLKS_PER_BIT SHALL equal CLK_HZ/BAUD, integer-truncated; that is 217 at the defaults.
REQ-011 HALF_BIT SHALL equal CLKS_PER_BIT/2, which is 108.
REQ-012 rx SHALL pass through a 2-flop synchronizer, both flops reset to 1, before any use; rx_s denotes the synchronized value.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, STOP.
REQ-014 IDLE: when rx_s is 0, the FSM SHALL go to START, clear the bit counter to 0 and set busy.
REQ-015 START: after HALF_BIT clocks, if rx_s is 0 the FSM SHALL go to DATA and reload the counter; if rx_s is 1 it SHALL treat the event as a glitch, return to IDLE and clear busy, with no strobe.
REQ-016 DATA: every CLKS_PER_BIT clocks the FSM SHALL sample rx_s into a shift register, LSB first; after the 8th sample it SHALL go to STOP.
REQ-017 STOP: after CLKS_PER_BIT clocks the FSM SHALL sample rx_s.
REQ-018 If the stop sample is 1, data SHALL take the shift register, valid SHALL pulse for exactly 1 cycle, and frame_err SHALL stay 0.
REQ-019 If the stop sample is 0, frame_err SHALL pulse for 1 cycle and data and valid SHALL stay unchanged.
REQ-020 After the stop sample the FSM SHALL return to IDLE in the same cycle and clear busy; a start edge on the very next cycle SHALL be accepted, so back-to-back frames need no gap.
REQ-021 After a framing error with rx held low, IDLE SHALL see rx_s=0 and re-enter START; this is permitted, and such a frame ends in frame_err or a valid byte on its own merits.
REQ-022 valid SHALL assert 2 synchronizer clocks + HALF_BIT + 9×CLKS_PER_BIT clocks, ±1, after the rx falling edge.
REQ-023 The baud counter SHALL be wide enough for CLKS_PER_BIT-1, i.e. clog2, and SHALL never wrap silently.
REQ-024 valid and frame_err SHALL never both be high in one cycle.

Reset
REQ-025 While rst_n is 0, the block SHALL hold state IDLE, data=8'h00, valid=0, busy=0, frame_err=0, counters=0 and both synchronizer flops=1.
REQ-026 A reset asserted mid-frame SHALL abort the frame with no strobe; after release the block SHALL wait for a fresh falling edge.
REQ-027 Reset release SHALL be synchronized externally; the block SHALL not generate an internal reset.

Structure
REQ-028 Package serial_pkg SHALL hold the state encoding (2-bit IDLE/START/DATA/STOP) and the function computing CLKS_PER_BIT from CLK_HZ and BAUD; SerialTX SHALL share the same function.
REQ-029 One sub-module, serial_sync (2-flop synchronizer with reset value parameter), SHALL be instantiated for rx; everything else SHALL be inline.

Verification
REQ-030 Loopback: SerialTX tx to rx, send 8'hDE at defaults -> exactly one valid, data=8'hDE, frame_err never high.
REQ-031 Back-to-back: frames 8'h55 then 8'hAA with zero idle gap -> two valid pulses, data 8'h55 then 8'hAA.
REQ-032 Glitch: rx low for 50 clocks, then high -> busy high about 108 clocks, then 0, with no valid and no frame_err.
REQ-033 Framing: frame 8'hFF with the stop bit driven 0 -> frame_err pulses once, valid stays 0, and data keeps its prior value.
REQ-034 Reset mid-frame: rst_n low during bit 4 of 8'hDE, then released, then a clean 8'h3C sent -> no strobe for the aborted frame, and valid with data=8'h3C afterwards.
REQ-035 Baud tolerance: a stimulus bit period of 217±4 clocks -> 8'hDE is still received correctly.
